// File: rtl/inst_loader_if.sv
// Stream-in and instruction-memory write bundle for the program loader.
// master = loader side, slave = byte source / memory / core side.
interface inst_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [WORD_WIDTH-1:0] mem_write_data;
    logic                  core_hold;
    logic                  done;
    logic                  error;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_write_enable,
        output mem_write_addr,
        output mem_write_data,
        output core_hold,
        output done,
        output error
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_write_enable,
        input  mem_write_addr,
        input  mem_write_data,
        input  core_hold,
        input  done,
        input  error
    );
endinterface

// File: rtl/inst_loader.sv
// Serial program loader: header byte N, then 4*N little-endian payload bytes,
// one instruction-memory write per word; holds the core until the load completes.
module inst_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_loader_if.master        bus
);
    localparam int CW        = ADDR_WIDTH + 1;
    localparam int MAX_WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HEADER,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [23:0]           asm_q;
    logic                  in_ready_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WORD_WIDTH-1:0] mem_data_q;
    logic                  core_hold_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic                  header_ok;
    logic [CW-1:0]         word_idx_inc;

    assign accept       = bus.in_valid & in_ready_q;
    assign header_ok    = (bus.in_data != 8'd0) && (32'(bus.in_data) <= MAX_WORDS);
    assign word_idx_inc = word_idx_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HEADER;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_HEADER: begin
                    if (accept) begin
                        if (header_ok) begin
                            count_q    <= CW'(bus.in_data);
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                            state_q    <= S_LOAD;
                        end else begin
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                            state_q    <= S_ERROR;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= bus.in_data;
                            2'd1: asm_q[15:8]  <= bus.in_data;
                            2'd2: asm_q[23:16] <= bus.in_data;
                            default: begin
                                // Lane 3 goes straight into the write data register.
                                mem_data_q <= WORD_WIDTH'({bus.in_data, asm_q});
                                mem_addr_q <= word_idx_q[ADDR_WIDTH-1:0];
                                mem_we_q   <= 1'b1;
                                in_ready_q <= 1'b0;
                                state_q    <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    mem_we_q   <= 1'b0;
                    word_idx_q <= word_idx_inc;
                    if (word_idx_inc == count_q) begin
                        core_hold_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        byte_idx_q <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    in_ready_q <= 1'b0;
                end
                S_ERROR: begin
                    in_ready_q <= 1'b0;
                    error_q    <= 1'b1;
                end
                default: begin
                    state_q <= S_HEADER;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_write_addr   = mem_addr_q;
    assign bus.mem_write_data   = mem_data_q;
    assign bus.core_hold        = core_hold_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;
endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader: normal loads, stalls, full
// 32-word program, illegal headers, mid-load reset and post-done behaviour.
module tb_inst_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_loader_if bus ();

    inst_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-strobe log and in_ready-vs-strobe monitor, sampled mid-cycle.
    int          wr_cnt = 0;
    logic [4:0]  wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    bit          mon_ready = 1'b0;
    int          ready_viol = 0;

    always @(negedge clk) begin
        if (bus.mem_write_enable === 1'b1) begin
            if (wr_cnt < 256) begin
                wr_addr[wr_cnt] = bus.mem_write_addr;
                wr_data[wr_cnt] = bus.mem_write_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (mon_ready && (bus.in_ready !== ~bus.mem_write_enable))
            ready_viol = ready_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a byte until it is accepted (bounded); returns at edge+1.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("byte_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int          base;
    int          c0;
    int          bad;
    int          ready_hi;
    logic [7:0]  b;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // ---------------- reset values
        do_reset();
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("rst_we",        {31'd0, bus.mem_write_enable}, 32'd0);
        check("rst_addr",      {27'd0, bus.mem_write_addr}, 32'd0);
        check("rst_data",      bus.mem_write_data, 32'h0);
        check("rst_core_hold", {31'd0, bus.core_hold}, 32'd1);
        check("rst_done",      {31'd0, bus.done}, 32'd0);
        check("rst_error",     {31'd0, bus.error}, 32'd0);

        // ---------------- T1: one word back-to-back
        base = wr_cnt;
        send_byte(8'h01);
        c0 = cyc;
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h00);
        check("t1_we",        {31'd0, bus.mem_write_enable}, 32'd1);
        check("t1_addr",      {27'd0, bus.mem_write_addr}, 32'd0);
        check("t1_data",      bus.mem_write_data, 32'h00100513);
        check("t1_ready_wr",  {31'd0, bus.in_ready}, 32'd0);
        check("t1_done_wr",   {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_we_low",    {31'd0, bus.mem_write_enable}, 32'd0);
        check("t1_done",      {31'd0, bus.done}, 32'd1);
        check("t1_core_hold", {31'd0, bus.core_hold}, 32'd0);
        check("t1_latency",   cyc - c0, 32'd5);
        check("t1_strobes",   wr_cnt - base, 32'd1);

        // ---------------- T2: two words with a 3-cycle gap
        do_reset();
        base = wr_cnt;
        ready_viol = 0;
        mon_ready = 1'b1;
        send_byte(8'h02);
        send_byte(8'h78);
        send_byte(8'h56);
        repeat (3) @(posedge clk);
        #1;
        check("t2_gap_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t2_gap_nowr",  wr_cnt - base, 32'd0);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        check("t2_last_we",   {31'd0, bus.mem_write_enable}, 32'd1);
        #5;
        mon_ready = 1'b0;
        @(posedge clk);
        #1;
        check("t2_strobes",   wr_cnt - base, 32'd2);
        check("t2_addr0",     {27'd0, wr_addr[base]}, 32'd0);
        check("t2_data0",     wr_data[base], 32'h12345678);
        check("t2_addr1",     {27'd0, wr_addr[base+1]}, 32'd1);
        check("t2_data1",     wr_data[base+1], 32'hDEADBEEF);
        check("t2_ready_viol", ready_viol, 32'd0);
        check("t2_done",      {31'd0, bus.done}, 32'd1);

        // ---------------- T3: full 32-word program
        do_reset();
        base = wr_cnt;
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            for (int k = 0; k < 4; k++) send_byte(b);
        end
        @(posedge clk);
        #1;
        check("t3_strobes",   wr_cnt - base, 32'd32);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            if (wr_addr[base+i] !== 5'(i) || wr_data[base+i] !== {4{b}}) bad++;
        end
        check("t3_order",     bad, 32'd0);
        check("t3_addr31",    {27'd0, wr_addr[base+31]}, 32'd31);
        check("t3_data31",    wr_data[base+31], 32'h1F1F1F1F);
        check("t3_done",      {31'd0, bus.done}, 32'd1);
        check("t3_core_hold", {31'd0, bus.core_hold}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t3_no_wrap",   wr_cnt - base, 32'd32);

        // ---------------- T4: illegal headers 0x00 and 0x21
        do_reset();
        base = wr_cnt;
        send_byte(8'h00);
        check("t4a_error",     {31'd0, bus.error}, 32'd1);
        check("t4a_ready",     {31'd0, bus.in_ready}, 32'd0);
        check("t4a_core_hold", {31'd0, bus.core_hold}, 32'd1);
        check("t4a_done",      {31'd0, bus.done}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t4a_sticky",    {31'd0, bus.error}, 32'd1);
        do_reset();
        check("t4_rst_clears", {31'd0, bus.error}, 32'd0);
        send_byte(8'h21);
        check("t4b_error",     {31'd0, bus.error}, 32'd1);
        check("t4b_ready",     {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t4_no_strobes", wr_cnt - base, 32'd0);
        check("t4b_done",      {31'd0, bus.done}, 32'd0);
        check("t4b_core_hold", {31'd0, bus.core_hold}, 32'd1);

        // ---------------- T5: reset in the middle of a load
        do_reset();
        base = wr_cnt;
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        rst = 1'b1;
        #1;
        check("t5_async_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t5_async_hold",  {31'd0, bus.core_hold}, 32'd1);
        check("t5_async_addr",  {27'd0, bus.mem_write_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        @(posedge clk);
        #1;
        check("t5_strobes",   wr_cnt - base, 32'd2);
        check("t5_pre_addr",  {27'd0, wr_addr[base]}, 32'd0);
        check("t5_pre_data",  wr_data[base], 32'h44332211);
        check("t5_post_addr", {27'd0, wr_addr[base+1]}, 32'd0);
        check("t5_post_data", wr_data[base+1], 32'hDDCCBBAA);
        check("t5_done",      {31'd0, bus.done}, 32'd1);

        // ---------------- T6: stream after done is ignored
        base = wr_cnt;
        ready_hi = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready !== 1'b0 || bus.done !== 1'b1 || bus.core_hold !== 1'b0) ready_hi++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("t6_stable",    ready_hi, 32'd0);
        check("t6_strobes",   wr_cnt - base, 32'd0);
        check("t6_done",      {31'd0, bus.done}, 32'd1);
        check("t6_core_hold", {31'd0, bus.core_hold}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
# inst_loader

Serial program loader that fills the instruction memory before the single-cycle core runs. It accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words, and issues one write per word into the writable instruction memory port. It holds the core halted until the full program is written, then releases it. It is the writer side of the instruction-memory path that the core's fetch logic reads.

## Interface
- ADDR_WIDTH, 5, instruction memory address width (32 words)
- WORD_WIDTH, 32, instruction word width
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  source has a byte on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_write_enable  output  1  one-cycle instruction memory write strobe
- mem_write_addr  output  ADDR_WIDTH  word address of write
- mem_write_data  output  WORD_WIDTH  instruction word to write
- core_hold  output  1  1 = core PC frozen / core held; 0 = core runs
- done  output  1  program fully loaded
- error  output  1  illegal header received; sticky until rst

## Operation
- Stream format: 1 header byte N (word count, legal 1..32), then 4·N payload bytes, little-endian per word (byte k of a word → bits [8k+7:8k]).
- Byte accepted on a rising edge where in_valid & in_ready = 1. in_data ignored otherwise.
- States:
  - HEADER: in_ready=1. On accept: N in 1..32 → store N in 6-bit count, word index=0, byte index=0, go LOAD. N=0 or N>32 → go ERROR.
  - LOAD: in_ready=1. On accept: place byte at lane byte index; byte index (2 bits) increments. When fourth byte (index 3) accepted → go WRITE.
  - WRITE: exactly one cycle. mem_write_enable=1, mem_write_addr=word index[4:0], mem_write_data=assembled word, in_ready=0. Leaving WRITE: word index+1; if new index == N → go DONE, else byte index=0, go LOAD.
  - DONE: core_hold=0, done=1, in_ready=0. Terminal until rst; further stream bytes not accepted.
  - ERROR: error=1, core_hold=1, in_ready=0, no writes. Terminal until rst.
- core_hold=1 in HEADER, LOAD, WRITE, ERROR.
- Word index is 6 bits; N=32 writes addresses 0..31, final index 32 compared against N, no address wrap onto 0.
- Assembly register not cleared between words; every lane overwritten before each write.

## Timing
- Reset values (asynchronous, effective immediately): state=HEADER, in_ready=1, mem_write_enable=0, mem_write_addr=0, mem_write_data=0, core_hold=1, done=0, error=0, all counters 0.
- All outputs registered / decoded from registered state; no combinational path from in_valid or in_data to any output.
- Write latency: mem_write_enable asserted in the cycle immediately after the edge accepting a word's fourth byte; high exactly one cycle.
- Minimum load time for N words: 1 + 5·N cycles (header, then 4 bytes + 1 write cycle per word).
- Gaps in in_valid stall LOAD indefinitely; partial word retained, no timeout.
- core_hold falls and done rises together, in the cycle after the final WRITE cycle.
- rst asserted mid-load: all state to reset values; memory contents already written are not erased; next accepted byte is treated as a header.
- rst deasserted: first accept possible on the first rising edge with rst low.

## Test plan
- Header 0x01, bytes 0x13,0x05,0x10,0x00 back-to-back → one strobe, addr 0, data 0x00100513; done=1 and core_hold=0 one cycle later; total 6 cycles after first accept.
- Header 0x02, 8 bytes with in_valid dropped for 3 cycles between bytes 2 and 3 → writes at addr 0 then 1 with correct words; in_ready low only in WRITE cycles; no extra strobes.
- Header 0x20 (32), 128 bytes where word i = {4{i[7:0]}} → 32 strobes, addr 0..31 in order, data 0x1F1F1F1F at addr 31; done after the 32nd write; no write to addr 0 afterwards.
- Header 0x00, then header 0x21 after a fresh rst → error=1, in_ready=0, core_hold=1, mem_write_enable never asserted, done=0.
- Header 0x03, rst pulsed after 6 payload bytes, then header 0x01 + 4 bytes → only post-reset word written at addr 0 (one pre-reset write at addr 0 allowed and overwritten); done=1.
- After done, in_valid held high with data 0xFF for 10 cycles → in_ready=0, no strobes, done and core_hold stable.
